// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: loads an operand, shifts it one bit per clock for a
// programmed count (logical, arithmetic or rotate, either direction) and holds the result.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic             lr_i,
  input  logic [1:0]       mode_i,
  input  logic [SHW-1:0]   amt_i,
  output logic [WIDTH-1:0] z_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1'b1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             lr_q, lr_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One single-bit step; the fill bit is the only thing that differs between modes.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic             right,
    input logic [1:0]       md
  );
    logic fill;
    case (md)
      MODE_ROT:   fill = right ? v[0] : v[WIDTH-1];
      MODE_ARITH: fill = right ? v[WIDTH-1] : 1'b0;
      default:    fill = 1'b0;
    endcase
    if (right) begin
      shift_step = {fill, v[WIDTH-1:1]};
    end else begin
      shift_step = {v[WIDTH-2:0], fill};
    end
  endfunction

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          z_d    = x_i;
          cnt_d  = amt_i;
          lr_d   = lr_i;
          mode_d = mode_i;
          if (amt_i != CNT_ZERO) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        z_d = shift_step(z_q, lr_q, mode_q);
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // done trails the DONE state by one cycle, so busy is stretched to fall together with it.
  always_comb begin
    done_d = (state_q == ST_DONE);
    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      z_q     <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      lr_q    <= 1'b0;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign z_o    = z_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
